// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module  : i2c_target_regfile
// Purpose : I2C target (slave) in front of a byte-wide register file.
//           Supports a pointer-set write, burst writes, burst reads with
//           pointer auto-increment and wrap, repeated START and address
//           filtering. A host port reads registers and observes bus writes.
// Ports   : sys_clk / sys_rst_n    system clock, async active-low reset
//           i2c_scl_i / i2c_sda_i  bus pin inputs (SCL is never driven)
//           i2c_sda_oe             1 = pull SDA low, 0 = release
//           host_addr / host_rdata registered host read of regs[host_addr]
//           wr_strobe / wr_addr / wr_data  one pulse per bus-written byte
//           busy                   high from START until STOP
// Revision: 1.0  initial release
// ============================================================================
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         NUM_REGS    = 64,
  parameter int         AW          = $clog2(NUM_REGS),
  parameter int         SYNC_STAGES = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          i2c_scl_i,
  input  logic          i2c_sda_i,
  output logic          i2c_sda_oe,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WDATA    = 4'd5,
    ST_WACK     = 4'd6,
    ST_RDATA    = 4'd7,
    ST_RACK     = 4'd8,
    ST_IGNORE   = 4'd9
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchronisers plus one history flop for edge detection. Reset to 1
  // so an idle (pulled-up) bus produces no spurious edges after reset.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda_i};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s &  scl_hist_q;
  // SCL must be high on both samples so an SDA change coincident with an SCL
  // edge is never mistaken for START/STOP.
  assign start_det = scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e        state_q,   state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;   // SCL rising edges seen in this byte
  logic [7:0]    shreg_q,   shreg_d;     // receive / transmit shift register
  logic [AW-1:0] ptr_q,     ptr_d;
  logic          sda_oe_q,  sda_oe_d;
  logic          mnack_q,   mnack_d;     // master's ACK bit in a read (1 = NACK)
  logic          wr_fire;                // commit shreg_q to regs[ptr_q]

  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    rd_byte;

  assign rd_byte = regs_q[ptr_q];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'd0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      mnack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      mnack_q   <= mnack_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. SDA drive only changes on a detected SCL falling edge
  // (or is released by START/STOP), so it is never altered while SCL is high.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    mnack_d   = mnack_q;
    wr_fire   = 1'b0;

    if (start_det) begin
      // Fresh or repeated START: any partial byte is dropped, pointer kept.
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // Byte complete; this falling edge opens the ACK bit.
            bit_cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (shreg_q[7:1] == SLAVE_ADDR) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d    = AW'(shreg_q);
              state_d  = ST_PTR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = ST_WACK;
              sda_oe_d = 1'b1;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (shreg_q[0]) begin
              // Read: put the MSB of the current register on the bus.
              state_d   = ST_RDATA;
              shreg_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 4'd0;
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_PTR_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WDATA;
            sda_oe_d = 1'b0;
          end
        end

        ST_WACK: begin
          if (scl_rise) begin
            wr_fire = 1'b1;
            ptr_d   = ptr_q + AW'(1);
          end else if (scl_fall) begin
            state_d  = ST_WDATA;
            sda_oe_d = 1'b0;
          end
        end

        ST_RDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              // shreg_q[7] has just been sent; bit 6 becomes the next one.
              sda_oe_d = ~shreg_q[6];
              shreg_d  = {shreg_q[6:0], 1'b0};
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            mnack_d = sda_s;
            ptr_d   = ptr_q + AW'(1);
          end else if (scl_fall) begin
            if (!mnack_q) begin
              // ptr_q already advanced on the rising edge.
              state_d   = ST_RDATA;
              shreg_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 4'd0;
            end else begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end

        default: ; // ST_IDLE / ST_IGNORE wait for START or STOP
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file, write notification and host read port
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else if (wr_fire) begin
      regs_q[ptr_q] <= shreg_q;
    end
  end

  logic          wr_strobe_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    host_rdata_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
      host_rdata_q <= 8'd0;
    end else begin
      wr_strobe_q  <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= shreg_q;
      end
      host_rdata_q <= regs_q[host_addr];
    end
  end

  assign i2c_sda_oe = sda_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_target_regfile
// Purpose : Self-checking bench for i2c_target_regfile. A bit-banged I2C
//           master drives an open-drain bus model; a register-array model
//           with a pointer predicts ACKs, read data, write strobes and host
//           read-back. Directed cases plus a randomized transaction mix.
// Revision: 1.0  initial release
// ============================================================================
module tb_i2c_target_regfile;

  localparam int NR = 64;
  localparam int Q  = 6;          // sys_clk cycles per quarter SCL bit

  logic       clk;
  logic       rst_n;
  logic       m_scl, m_sda;
  logic       sda_line;
  logic       i2c_sda_oe;
  logic [5:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda_line = m_sda & ~i2c_sda_oe;   // open-drain wired-AND

  i2c_target_regfile #(
    .SLAVE_ADDR (7'h68),
    .NUM_REGS   (NR),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .i2c_scl_i  (m_scl),
    .i2c_sda_i  (sda_line),
    .i2c_sda_oe (i2c_sda_oe),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  mregs [NR];
  int          mptr;
  logic [13:0] exp_wr_q [$];     // {addr, data} expected on wr_strobe
  logic [7:0]  wbuf [$];         // data for the next write (random if empty)

  int n_cmp = 0;
  int n_bad = 0;
  int oe_hi_cnt = 0;
  int oe_viol = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
    exp_wr_q.delete();
  endtask

  // ---------------- monitors ----------------
  logic prev_oe, prev_scl;
  initial begin prev_oe = 1'b0; prev_scl = 1'b1; end

  always @(negedge clk) begin
    if (rst_n) begin
      if (i2c_sda_oe) oe_hi_cnt++;
      if (m_scl && prev_scl && (i2c_sda_oe != prev_oe)) oe_viol++;
      if (wr_strobe) begin
        if (exp_wr_q.size() == 0) check_eq("wr_unexpected", wr_strobe, 0);
        else check_eq("wr_addr_data", {wr_addr, wr_data}, exp_wr_q.pop_front());
      end
    end
    prev_oe  = i2c_sda_oe;
    prev_scl = m_scl;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  // ---------------- bus master ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    tick(Q); m_sda = b; tick(Q); m_scl = 1'b1; tick(Q); r = sda_line; tick(Q); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    m_sda = 1'b1;
    acked = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      d = {d[6:0], r};
    end
    bus_bit(nack, r);
    m_sda = 1'b1;
  endtask

  // ---------------- transactions (model updated alongside) ----------------
  task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input int n);
    logic       ack, hit;
    logic [7:0] d;
    hit = (a == 7'h68);
    bus_start();
    check_eq("busy_start", busy, 1);
    write_byte({a, 1'b0}, ack); check_eq("addr_ack", ack, hit);
    write_byte(p, ack);         check_eq("ptr_ack", ack, hit);
    if (hit) mptr = p % NR;
    for (int i = 0; i < n; i++) begin
      d = (wbuf.size() > 0) ? wbuf.pop_front() : 8'($urandom);
      if (hit) exp_wr_q.push_back({6'(mptr), d});
      write_byte(d, ack); check_eq("wdata_ack", ack, hit);
      if (hit) begin
        mregs[mptr] = d;
        mptr = (mptr + 1) % NR;
      end
    end
    bus_stop();
    tick(4);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hD0, ack); check_eq("rd_waddr_ack", ack, 1);
      write_byte(p, ack);     check_eq("rd_ptr_ack", ack, 1);
      mptr = p % NR;
      bus_start();            // repeated START
    end
    write_byte(8'hD1, ack); check_eq("rd_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check_eq("rdata", d, mregs[mptr]);
      mptr = (mptr + 1) % NR;
    end
    bus_stop();
    tick(4);
    check_eq("busy_idle_rd", busy, 0);
  endtask

  task automatic host_sweep();
    for (int a = 0; a < NR; a++) begin
      host_addr = 6'(a);
      tick(2);
      check_eq("host_rdata", host_rdata, mregs[a]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic       ack;
    logic [6:0] ra;
    int         kind;

    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; host_addr = '0;
    model_reset();
    tick(3);
    check_eq("rst_sda_oe", i2c_sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_host_rdata", host_rdata, 0);
    rst_n = 1'b1;
    tick(5);

    // Seed reg 7 so the "pointer ends at 7" read sees a non-zero value.
    wbuf = '{8'h77};             txn_write(7'h68, 8'h07, 1);
    // Write burst then pointer-set read with repeated START.
    wbuf = '{8'h11, 8'h22};      txn_write(7'h68, 8'h05, 2);
    txn_read(1'b1, 8'h05, 2);
    txn_read(1'b0, 8'h00, 1);    // continues at pointer 7

    // Wrong address: target must never drive SDA.
    oe_hi_cnt = 0;
    wbuf = '{8'h55};             txn_write(7'h50, 8'h00, 1);
    check_eq("wrong_addr_oe", oe_hi_cnt, 0);

    // Wrap-around on write and read.
    wbuf = '{8'hAA, 8'hBB};      txn_write(7'h68, 8'h3F, 2);
    txn_read(1'b1, 8'h3F, 2);

    // Pointer masking: 0x45 lands in reg 5.
    wbuf = '{8'hC3};             txn_write(7'h68, 8'h45, 1);
    host_sweep();

    // Reset while the target drives a 0 data bit.
    wbuf = '{8'h3C};             txn_write(7'h68, 8'h0A, 1);
    bus_start();
    write_byte(8'hD0, ack); check_eq("rst_seq_ack0", ack, 1);
    write_byte(8'h0A, ack); check_eq("rst_seq_ack1", ack, 1);
    bus_start();
    write_byte(8'hD1, ack); check_eq("rst_seq_ack2", ack, 1);
    tick(Q);
    check_eq("rd_drive0", i2c_sda_oe, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async_oe", i2c_sda_oe, 0);
    tick(3);
    model_reset();
    rst_n = 1'b1;
    bus_stop();
    tick(4);
    check_eq("post_rst_busy", busy, 0);
    host_sweep();
    txn_write(7'h68, 8'($urandom), 2);
    txn_read(1'b0, 8'h00, 2);

    // Randomized transaction mix.
    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: txn_write(7'h68, 8'($urandom), $urandom_range(1, 4));
        1: txn_read(1'b1, 8'($urandom), $urandom_range(1, 4));
        2: txn_read(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          ra = 7'($urandom);
          if (ra == 7'h68) ra = 7'h69;
          oe_hi_cnt = 0;
          txn_write(ra, 8'($urandom), $urandom_range(1, 2));
          check_eq("rand_wrong_addr_oe", oe_hi_cnt, 0);
        end
      endcase
    end
    host_sweep();

    tick(4);
    check_eq("wr_pending", exp_wr_q.size(), 0);
    check_eq("oe_change_scl_high", oe_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
